// File: rtl/mips_lsu_if.sv
// Core request/response channel plus the byte-lane data memory port of the load/store unit.
// Buses are XLEN bits wide with lane 0 (lowest address) in the most significant byte.
interface mips_lsu_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic            req_write;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_fault;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_data_out;
  logic [XLEN-1:0] mem_data_in;
  logic            mem_write_en;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_data_in, mem_write_en
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_fault, mem_addr, mem_data_in, mem_write_en
  );
endinterface

// File: rtl/mips_lsu.sv
// Big-endian load/store unit; resp after 1 (fault), 2 (full store), MEM_LATENCY+1 (load) or MEM_LATENCY+2 (RMW store) cycles.
// One request in flight: req_ready is high only in IDLE and requests seen while busy are dropped.
module mips_lsu #(
  parameter int XLEN        = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic      clk,
  input  logic      rst_b,
  mips_lsu_if.slave bus
);
  localparam int         LANES   = XLEN / 8;
  localparam int         OW      = $clog2(LANES);
  localparam int         CW      = $clog2(MEM_LATENCY + 1);
  localparam logic [3:0] LANES_B = 4'(LANES);

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR, RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [OW-1:0]   r_off;
  logic [3:0]      r_bytes;
  logic            r_uns;
  logic            r_write;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_wbuf;
  logic [XLEN-1:0] r_rdata;
  logic            r_fault;
  logic [XLEN-1:0] r_mem_addr;

  logic [3:0]      w_req_bytes;
  logic            w_misalign;
  logic            w_fault;
  logic            w_full;
  logic            w_accept;
  logic            w_capture;
  logic [6:0]      w_rsh;
  logic [XLEN-1:0] w_mask;
  logic [XLEN-1:0] w_sel;
  logic            w_sign;
  logic [XLEN-1:0] w_ext;
  logic [3:0]      w_end;
  logic [6:0]      w_pos;
  logic [XLEN-1:0] w_merged;

  assign w_req_bytes = 4'd1 << bus.req_size;
  assign w_misalign  = ((bus.req_size == 2'd1) &  bus.req_addr[0])
                     | ((bus.req_size == 2'd2) & |bus.req_addr[1:0])
                     | ((bus.req_size == 2'd3) & |bus.req_addr[2:0]);
  assign w_fault     = (w_req_bytes > LANES_B) | w_misalign;
  assign w_full      = (w_req_bytes == LANES_B);
  assign w_accept    = (r_state == IDLE) & bus.req_valid;
  assign w_capture   = (r_state == RD_WAIT) & (r_cnt == CW'(1));

  // Load path: left-justify the target lanes, then right-justify them to the access width.
  assign w_rsh  = 7'(XLEN) - {r_bytes, 3'b000};
  assign w_mask = {XLEN{1'b1}} >> w_rsh;
  assign w_sel  = (bus.mem_data_out << {r_off, 3'b000}) >> w_rsh;
  assign w_sign = ~r_uns & |(w_sel & w_mask & ~(w_mask >> 1));
  assign w_ext  = w_sel | ({XLEN{w_sign}} & ~w_mask);

  // Store path: splice the low bytes of the store data into the lanes just read.
  assign w_end    = 4'(r_off) + r_bytes;
  assign w_pos    = 7'(XLEN) - {w_end, 3'b000};
  assign w_merged = (bus.mem_data_out & ~(w_mask << w_pos)) | ((r_wdata & w_mask) << w_pos);

  always_ff @(posedge clk) begin
    if (rst_b) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          if (w_fault)                     w_next = RESP;
          else if (bus.req_write && w_full) w_next = WR;
          else                              w_next = RD_WAIT;
        end
      end
      RD_WAIT: if (w_capture) w_next = r_write ? WR : RESP;
      WR:      w_next = RESP;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_off      <= '0;
      r_bytes    <= '0;
      r_uns      <= 1'b0;
      r_write    <= 1'b0;
      r_cnt      <= '0;
      r_wdata    <= '0;
      r_wbuf     <= '0;
      r_rdata    <= '0;
      r_fault    <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      if (w_accept) begin
        r_off      <= bus.req_addr[OW-1:0];
        r_bytes    <= w_req_bytes;
        r_uns      <= bus.req_unsigned;
        r_write    <= bus.req_write;
        r_wdata    <= bus.req_wdata;
        r_wbuf     <= bus.req_wdata;
        r_cnt      <= CW'(MEM_LATENCY);
        r_fault    <= w_fault;
        r_mem_addr <= {bus.req_addr[XLEN-1:OW], {OW{1'b0}}};
      end
      if (r_state == RD_WAIT) begin
        r_cnt <= r_cnt - CW'(1);
        if (w_capture) begin
          if (r_write) r_wbuf  <= w_merged;
          else         r_rdata <= w_ext;
        end
      end
      if (r_state == RESP) begin
        r_rdata <= '0;
        r_fault <= 1'b0;
      end
    end
  end

  assign bus.req_ready    = (r_state == IDLE);
  assign bus.resp_valid   = (r_state == RESP);
  assign bus.resp_rdata   = r_rdata;
  assign bus.resp_fault   = r_fault;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_write_en = (r_state == WR);
  assign bus.mem_data_in  = (r_state == WR) ? r_wbuf : '0;
endmodule

// File: tb/tb_mips_lsu.sv
// Drives a 32-bit/latency-2 and a 64-bit/latency-1 LSU against byte-array memories,
// checking table vectors, multi-cycle corner sequences and random traffic against a byte-level model.
module tb_mips_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst32, rst64, mem_init;
  int   tests = 0;
  int   fails = 0;

  mips_lsu_if #(.XLEN(32)) b32 ();
  mips_lsu_if #(.XLEN(64)) b64 ();

  mips_lsu #(.XLEN(32), .MEM_LATENCY(2)) u32 (.clk(clk), .rst_b(rst32), .bus(b32.slave));
  mips_lsu #(.XLEN(64), .MEM_LATENCY(1)) u64 (.clk(clk), .rst_b(rst64), .bus(b64.slave));

  logic [7:0] mem32 [512];
  logic [7:0] mem64 [512];
  logic [7:0] ref32 [512];
  logic [7:0] ref64 [512];

  function automatic logic [7:0] init_byte(input bit sel, input int a);
    logic [7:0] b;
    b = 8'(a * 37 + 11) ^ (sel ? 8'h5A : 8'h00);
    if (!sel) begin
      case (a)
        256: b = 8'h80;
        257: b = 8'h12;
        258: b = 8'h34;
        259: b = 8'h56;
        default: ;
      endcase
    end else if (a >= 8 && a < 16) begin
      b = 8'(a - 7);
    end
    return b;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) begin
        mem32[i] <= init_byte(1'b0, i);
        mem64[i] <= init_byte(1'b1, i);
      end
    end else begin
      if (b32.mem_write_en)
        for (int i = 0; i < 4; i++)
          mem32[(int'(b32.mem_addr[8:0]) + i) % 512] <= b32.mem_data_in[8*(3-i) +: 8];
      if (b64.mem_write_en)
        for (int i = 0; i < 8; i++)
          mem64[(int'(b64.mem_addr[8:0]) + i) % 512] <= b64.mem_data_in[8*(7-i) +: 8];
    end
  end

  always_comb begin
    b32.mem_data_out = '0;
    b64.mem_data_out = '0;
    for (int i = 0; i < 4; i++)
      b32.mem_data_out[8*(3-i) +: 8] = mem32[(int'(b32.mem_addr[8:0]) + i) % 512];
    for (int i = 0; i < 8; i++)
      b64.mem_data_out[8*(7-i) +: 8] = mem64[(int'(b64.mem_addr[8:0]) + i) % 512];
  end

  function automatic logic o_rv(input bit sel);
    return sel ? b64.resp_valid : b32.resp_valid;
  endfunction
  function automatic logic o_rdy(input bit sel);
    return sel ? b64.req_ready : b32.req_ready;
  endfunction
  function automatic logic o_we(input bit sel);
    return sel ? b64.mem_write_en : b32.mem_write_en;
  endfunction
  function automatic logic o_fault(input bit sel);
    return sel ? b64.resp_fault : b32.resp_fault;
  endfunction
  function automatic logic [63:0] o_rdata(input bit sel);
    return sel ? b64.resp_rdata : {32'd0, b32.resp_rdata};
  endfunction
  function automatic logic [63:0] o_maddr(input bit sel);
    return sel ? b64.mem_addr : {32'd0, b32.mem_addr};
  endfunction
  function automatic logic [63:0] o_mdin(input bit sel);
    return sel ? b64.mem_data_in : {32'd0, b32.mem_data_in};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit v, input bit wr, input logic [1:0] sz,
                       input bit uns, input logic [63:0] addr, input logic [63:0] wd);
    if (sel) begin
      b64.req_valid = v; b64.req_write = wr; b64.req_size = sz;
      b64.req_unsigned = uns; b64.req_addr = addr; b64.req_wdata = wd;
    end else begin
      b32.req_valid = v; b32.req_write = wr; b32.req_size = sz;
      b32.req_unsigned = uns; b32.req_addr = addr[31:0]; b32.req_wdata = wd[31:0];
    end
  endtask

  // Reference: byte-addressed big-endian memory, alignment rule and fixed latencies.
  task automatic model(input bit sel, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [63:0] addr, input logic [63:0] wd,
                       output logic [63:0] er, output bit ef, output int el, output int en);
    int lanes = sel ? 8 : 4;
    int lat   = sel ? 1 : 2;
    int nb    = 1 << sz;
    int base  = int'(addr[8:0]);
    logic [63:0] v = '0;
    er = '0; ef = 1'b0; en = 0;
    if (nb > lanes || (base % nb) != 0) begin
      ef = 1'b1; el = 1;
    end else if (wr) begin
      for (int i = 0; i < nb; i++) begin
        if (sel) ref64[(base + i) % 512] = 8'(wd >> (8 * (nb - 1 - i)));
        else     ref32[(base + i) % 512] = 8'(wd >> (8 * (nb - 1 - i)));
      end
      el = (nb == lanes) ? 2 : lat + 2;
      en = 1;
    end else begin
      for (int i = 0; i < nb; i++)
        v = (v << 8) | {56'd0, sel ? ref64[(base + i) % 512] : ref32[(base + i) % 512]};
      if (!uns && v[8*nb-1]) v = v | (~64'd0 << (8 * nb));
      if (!sel) v = v & 64'hFFFF_FFFF;
      er = v; el = lat + 1;
    end
  endtask

  task automatic txn(input bit sel, input bit wr, input logic [1:0] sz, input bit uns,
                     input logic [63:0] addr, input logic [63:0] wd,
                     output logic [63:0] rd, output bit flt, output int lat, output int nwr,
                     output logic [63:0] wa, output logic [63:0] wdat);
    rd = '0; flt = 1'b0; lat = -1; nwr = 0; wa = '0; wdat = '0;
    @(negedge clk);
    drive(sel, 1'b1, wr, sz, uns, addr, wd);
    @(posedge clk);
    #1 drive(sel, 1'b0, wr, sz, uns, addr, wd);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (o_we(sel)) begin nwr++; wa = o_maddr(sel); wdat = o_mdin(sel); end
      if (o_rv(sel)) begin lat = k; rd = o_rdata(sel); flt = o_fault(sel); break; end
    end
    @(negedge clk);
    chk("resp pulse ends, ready back", {62'd0, o_rv(sel), o_rdy(sel)}, 64'd1);
  endtask

  typedef struct {
    bit          sel;
    bit          wr;
    logic [1:0]  sz;
    bit          uns;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] e_rdata;
    bit          e_fault;
    int          e_lat;
    int          e_nwr;
    logic [63:0] e_wa;
    logic [63:0] e_wdat;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  initial begin
    logic [63:0] rd, er, wa, wdat, wd, addr;
    bit          flt, ef, wr, uns, sel;
    logic [1:0]  sz;
    int          lat, nwr, el, en, bad;
    logic [6:0]  wmask, rmask, ymask;

    vecs[0]  = '{0, 0, 2'd0, 0, 64'h100, 64'h0,  64'hFFFF_FF80, 0, 3, 0, 64'h0, 64'h0};
    vecs[1]  = '{0, 0, 2'd0, 1, 64'h100, 64'h0,  64'h0000_0080, 0, 3, 0, 64'h0, 64'h0};
    vecs[2]  = '{0, 0, 2'd1, 0, 64'h102, 64'h0,  64'h0000_3456, 0, 3, 0, 64'h0, 64'h0};
    vecs[3]  = '{0, 0, 2'd1, 0, 64'h101, 64'h0,  64'h0,         1, 1, 0, 64'h0, 64'h0};
    vecs[4]  = '{0, 1, 2'd0, 0, 64'h103, 64'hAB, 64'h0,         0, 4, 1, 64'h100, 64'h801234AB};
    vecs[5]  = '{0, 0, 2'd2, 0, 64'h100, 64'h0,  64'h8012_34AB, 0, 3, 0, 64'h0, 64'h0};
    vecs[6]  = '{0, 1, 2'd2, 0, 64'h104, 64'hDEADBEEF, 64'h0,   0, 2, 1, 64'h104, 64'hDEADBEEF};
    vecs[7]  = '{0, 0, 2'd1, 0, 64'h104, 64'h0,  64'hFFFF_DEAD, 0, 3, 0, 64'h0, 64'h0};
    vecs[8]  = '{0, 0, 2'd3, 0, 64'h100, 64'h0,  64'h0,         1, 1, 0, 64'h0, 64'h0};
    vecs[9]  = '{0, 1, 2'd1, 0, 64'h106, 64'h1234, 64'h0,       0, 4, 1, 64'h104, 64'hDEAD1234};
    vecs[10] = '{0, 0, 2'd2, 0, 64'h104, 64'h0,  64'hDEAD_1234, 0, 3, 0, 64'h0, 64'h0};
    vecs[11] = '{0, 1, 2'd3, 0, 64'h108, 64'h55, 64'h0,         1, 1, 0, 64'h0, 64'h0};
    vecs[12] = '{1, 0, 2'd3, 0, 64'h08, 64'h0, 64'h0102030405060708, 0, 2, 0, 64'h0, 64'h0};
    vecs[13] = '{1, 1, 2'd2, 0, 64'h0C, 64'hF0000001, 64'h0,    0, 3, 1, 64'h08, 64'h01020304F0000001};
    vecs[14] = '{1, 0, 2'd2, 0, 64'h0C, 64'h0, 64'hFFFFFFFFF0000001, 0, 2, 0, 64'h0, 64'h0};
    vecs[15] = '{1, 0, 2'd2, 1, 64'h0C, 64'h0, 64'h00000000F0000001, 0, 2, 0, 64'h0, 64'h0};
    vecs[16] = '{1, 0, 2'd3, 0, 64'h04, 64'h0, 64'h0,           1, 1, 0, 64'h0, 64'h0};
    vecs[17] = '{1, 1, 2'd3, 0, 64'h10, 64'h1122334455667788, 64'h0, 0, 2, 1, 64'h10, 64'h1122334455667788};
    vecs[18] = '{1, 0, 2'd0, 0, 64'h17, 64'h0, 64'hFFFFFFFFFFFFFF88, 0, 2, 0, 64'h0, 64'h0};
    vecs[19] = '{1, 0, 2'd1, 1, 64'h12, 64'h0, 64'h3344,        0, 2, 0, 64'h0, 64'h0};
    vecs[20] = '{1, 0, 2'd2, 0, 64'h0E, 64'h0, 64'h0,           1, 1, 0, 64'h0, 64'h0};
    vecs[21] = '{1, 0, 2'd0, 1, 64'h08, 64'h0, 64'h01,          0, 2, 0, 64'h0, 64'h0};

    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 64'h0, 64'h0);
    rst32 = 1'b1; rst64 = 1'b1; mem_init = 1'b1;
    for (int i = 0; i < 512; i++) begin
      ref32[i] = init_byte(1'b0, i);
      ref64[i] = init_byte(1'b1, i);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset%0d req_ready", s),    {63'd0, o_rdy(bit'(s))},   64'd1);
      chk($sformatf("reset%0d resp_valid", s),   {63'd0, o_rv(bit'(s))},    64'd0);
      chk($sformatf("reset%0d resp_rdata", s),   o_rdata(bit'(s)),          64'd0);
      chk($sformatf("reset%0d resp_fault", s),   {63'd0, o_fault(bit'(s))}, 64'd0);
      chk($sformatf("reset%0d mem_addr", s),     o_maddr(bit'(s)),          64'd0);
      chk($sformatf("reset%0d mem_data_in", s),  o_mdin(bit'(s)),           64'd0);
      chk($sformatf("reset%0d mem_write_en", s), {63'd0, o_we(bit'(s))},    64'd0);
    end
    rst32 = 1'b0; rst64 = 1'b0; mem_init = 1'b0;

    for (int i = 0; i < NV; i++) begin
      model(vecs[i].sel, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, er, ef, el, en);
      txn(vecs[i].sel, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
          rd, flt, lat, nwr, wa, wdat);
      chk($sformatf("vec%0d rdata", i),   rd,              vecs[i].e_rdata);
      chk($sformatf("vec%0d fault", i),   {63'd0, flt},    {63'd0, vecs[i].e_fault});
      chk($sformatf("vec%0d latency", i), 64'(lat),        64'(vecs[i].e_lat));
      chk($sformatf("vec%0d writes", i),  64'(nwr),        64'(vecs[i].e_nwr));
      if (vecs[i].e_nwr == 1) begin
        chk($sformatf("vec%0d mem_addr", i),    wa,   vecs[i].e_wa);
        chk($sformatf("vec%0d mem_data_in", i), wdat, vecs[i].e_wdat);
      end
    end

    // Full store with req_valid held high: the second copy is only taken once back in IDLE.
    model(1'b0, 1'b1, 2'd2, 1'b0, 64'h10C, 64'hCAFEF00D, er, ef, el, en);
    model(1'b0, 1'b1, 2'd2, 1'b0, 64'h10C, 64'hCAFEF00D, er, ef, el, en);
    wmask = '0; rmask = '0; ymask = '0; wdat = '0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 64'h10C, 64'hCAFEF00D);
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      wmask[k] = o_we(1'b0);
      rmask[k] = o_rv(1'b0);
      ymask[k] = o_rdy(1'b0);
      if (k == 1) wdat = o_mdin(1'b0);
      if (k == 4) drive(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 64'h10C, 64'hCAFEF00D);
    end
    chk("b2b write cycles", {57'd0, wmask}, 64'b0010010);
    chk("b2b resp cycles",  {57'd0, rmask}, 64'b0100100);
    chk("b2b ready cycles", {57'd0, ymask}, 64'b1001000);
    chk("b2b write data",   wdat,           64'hCAFEF00D);

    // Reset while a read-modify-write store is still reading.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 64'h108, 64'h7777);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 64'h108, 64'h7777);
    rst32 = 1'b1;
    @(posedge clk);
    #1 rst32 = 1'b0;
    @(negedge clk);
    chk("abort req_ready",    {63'd0, o_rdy(1'b0)}, 64'd1);
    chk("abort mem_write_en", {63'd0, o_we(1'b0)},  64'd0);
    chk("abort mem_addr",     o_maddr(1'b0),        64'd0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (o_we(1'b0) || o_rv(1'b0)) bad++;
      @(negedge clk);
    end
    chk("abort no write/resp", 64'(bad), 64'd0);
    model(1'b0, 1'b0, 2'd2, 1'b0, 64'h108, 64'h0, er, ef, el, en);
    txn(1'b0, 1'b0, 2'd2, 1'b0, 64'h108, 64'h0, rd, flt, lat, nwr, wa, wdat);
    chk("abort memory unchanged", rd, er);

    for (int n = 0; n < 120; n++) begin
      sel  = bit'(n % 2);
      wr   = bit'($urandom_range(0, 1));
      uns  = bit'($urandom_range(0, 1));
      sz   = 2'($urandom_range(0, 3));
      addr = 64'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
      wd   = {$urandom, $urandom};
      model(sel, wr, sz, uns, addr, wd, er, ef, el, en);
      txn(sel, wr, sz, uns, addr, wd, rd, flt, lat, nwr, wa, wdat);
      chk($sformatf("rand%0d rdata", n),   rd,           er);
      chk($sformatf("rand%0d fault", n),   {63'd0, flt}, {63'd0, ef});
      chk($sformatf("rand%0d latency", n), 64'(lat),     64'(el));
      chk($sformatf("rand%0d writes", n),  64'(nwr),     64'(en));
    end

    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem32[i] !== ref32[i]) bad++;
    chk("mem32 image", 64'(bad), 64'd0);
    bad = 0;
    for (int i = 0; i < 512; i++) if (mem64[i] !== ref64[i]) bad++;
    chk("mem64 image", 64'(bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
